branch_resolver: RTL

//   Executes the control-flow ops (BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL, JALR) that the RS issues once operands are ready.

---
 rtl/branch_resolver.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// Branch resolver: queues issued control-flow ops in order, resolves the head
// (condition, target, link value, mispredict) and holds one result in an
// output register until the CDB grants it. Conditional branches also produce
// a one-cycle training pulse for the branch predictor.
module branch_resolver #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int PC_W  = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_rs1_val,
  input  logic [31:0]      in_rs2_val,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_pred_target,
  input  logic [TAG_W-1:0] in_tag,
  output logic             cdb_valid,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_value,
  output logic [31:0]      cdb_target,
  output logic             cdb_mispredict,
  output logic             train_ready,
  output logic             train_result,
  output logic [31:0]      train_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [31:0]      PC_MASK    = 32'((64'd1 << PC_W) - 64'd1);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [31:0]      rs1_val;
    logic [31:0]      rs2_val;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [31:0]      pred_target;
    logic [TAG_W-1:0] tag;
  } op_t;

  op_t              queue_mem [DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W:0]   count_reg;
  logic             train_ready_reg;

  op_t         in_op;
  op_t         head_op;
  logic        push;
  logic        pop;
  logic        head_branch;
  logic        head_jal;
  logic        head_jalr;
  logic        taken;
  logic [31:0] target_raw;
  logic [31:0] head_target;
  logic [31:0] head_value;
  logic        head_mispredict;

  assign in_op = {in_opcode, in_funct3, in_rs1_val, in_rs2_val, in_imm,
                  in_pc, in_pred_target, in_tag};

  // No bypass: a full queue refuses even when the head leaves this cycle.
  assign in_ready = rdy && (count_reg != FULL_COUNT);
  assign push     = in_valid && in_ready && !clr;
  assign pop      = rdy && !clr && (count_reg != '0) && (!cdb_valid || cdb_grant);
  assign head_op  = queue_mem[head_reg];

  // A pending pulse is hidden while the pipeline is frozen.
  assign train_ready = train_ready_reg && rdy;

  // Op storage; written at the tail, no reset needed since count gates use.
  always_ff @(posedge clk) begin
    if (push) begin
      queue_mem[tail_reg] <= in_op;
    end
  end

  // Resolve the head op: branch condition, target, link value, mispredict.
  always_comb begin
    head_branch = (head_op.opcode == OP_BRANCH);
    head_jal    = (head_op.opcode == OP_JAL);
    head_jalr   = (head_op.opcode == OP_JALR);
    taken       = 1'b0;
    case (head_op.funct3)
      3'b000:  taken = (head_op.rs1_val == head_op.rs2_val);
      3'b001:  taken = (head_op.rs1_val != head_op.rs2_val);
      3'b100:  taken = ($signed(head_op.rs1_val) <  $signed(head_op.rs2_val));
      3'b101:  taken = ($signed(head_op.rs1_val) >= $signed(head_op.rs2_val));
      3'b110:  taken = (head_op.rs1_val <  head_op.rs2_val);
      3'b111:  taken = (head_op.rs1_val >= head_op.rs2_val);
      default: taken = 1'b0;
    endcase
    target_raw = head_op.pc + 32'd4;
    if (head_jal) begin
      target_raw = head_op.pc + head_op.imm;
    end else if (head_jalr) begin
      target_raw = (head_op.rs1_val + head_op.imm) & 32'hFFFF_FFFE;
    end else if (head_branch && taken) begin
      target_raw = head_op.pc + head_op.imm;
    end
    head_target     = target_raw & PC_MASK;
    head_value      = (head_jal || head_jalr) ? ((head_op.pc + 32'd4) & PC_MASK) : 32'd0;
    head_mispredict = (head_target != (head_op.pred_target & PC_MASK));
  end

  // Queue pointers, occupancy, output register and training pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      cdb_valid       <= 1'b0;
      cdb_tag         <= '0;
      cdb_value       <= 32'd0;
      cdb_target      <= 32'd0;
      cdb_mispredict  <= 1'b0;
      train_ready_reg <= 1'b0;
      train_result    <= 1'b0;
      train_pc        <= 32'd0;
    end else if (rdy) begin
      if (clr) begin
        head_reg        <= '0;
        tail_reg        <= '0;
        count_reg       <= '0;
        cdb_valid       <= 1'b0;
        train_ready_reg <= 1'b0;
      end else begin
        if (push) begin
          tail_reg <= tail_reg + PTR_ONE;
        end
        if (pop) begin
          head_reg <= head_reg + PTR_ONE;
        end
        if (push && !pop) begin
          count_reg <= count_reg + CNT_ONE;
        end else if (!push && pop) begin
          count_reg <= count_reg - CNT_ONE;
        end
        train_ready_reg <= pop && head_branch;
        if (pop) begin
          cdb_valid      <= 1'b1;
          cdb_tag        <= head_op.tag;
          cdb_value      <= head_value;
          cdb_target     <= head_target;
          cdb_mispredict <= head_mispredict;
          if (head_branch) begin
            train_result <= taken;
            train_pc     <= head_op.pc;
          end
        end else if (cdb_grant) begin
          cdb_valid <= 1'b0;
        end
      end
    end
  end

endmodule
